// File: rtl/conv_window_mac.sv
// Window multiply-accumulate: tracks pixel position, qualifies complete patches
// and reduces patch x weights through a three-stage product/row/total pipeline.
module conv_window_mac #(
  parameter int WIN_W = 3,
  parameter int WIN_H = 3,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  localparam int N     = WIN_W * WIN_H,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H),
  localparam int RES_W = 16 + $clog2(N)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pixel_valid,
  input  logic [8*N-1:0]          window_in,
  input  logic [8*N-1:0]          weights,
  output logic signed [RES_W-1:0] result,
  output logic                    out_valid,
  output logic [CW-1:0]           out_col,
  output logic [RW-1:0]           out_row,
  output logic                    frame_done
);

  localparam int RSW = 16 + $clog2(WIN_W);

  localparam logic [CW-1:0] COL_MIN  = CW'(WIN_W - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic          v0_q, v0_d, fd0_q, fd0_d;
  logic [CW-1:0] col0_q, col0_d;
  logic [RW-1:0] row0_q, row0_d;

  logic              v1_q, v1_d, fd1_q, fd1_d;
  logic [CW-1:0]     col1_q, col1_d;
  logic [RW-1:0]     row1_q, row1_d;
  logic signed [15:0] prod_q [N];
  logic signed [15:0] prod_d [N];

  logic               v2_q, v2_d, fd2_q, fd2_d;
  logic [CW-1:0]      col2_q, col2_d;
  logic [RW-1:0]      row2_q, row2_d;
  logic signed [RSW-1:0] rsum_q [WIN_H];
  logic signed [RSW-1:0] rsum_d [WIN_H];

  logic                    ov_q, ov_d, fdo_q, fdo_d;
  logic [CW-1:0]           ocol_q, ocol_d;
  logic [RW-1:0]           orow_q, orow_d;
  logic signed [RES_W-1:0] res_q, res_d;

  // Position counters advance only when the shift register shifts.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    v0_d   = pixel_valid && (col_q >= COL_MIN) && (row_q >= ROW_MIN);
    fd0_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    col0_d = col_q;
    row0_d = row_q;
  end

  // The window shows the new pixel one cycle after it was accepted.
  always_comb begin
    v1_d   = v0_q;
    fd1_d  = fd0_q;
    col1_d = col0_q;
    row1_d = row0_q;
    for (int k = 0; k < N; k++) begin
      prod_d[k] = prod_q[k];
      if (v0_q) begin
        prod_d[k] = 16'($signed(window_in[8*k +: 8]))
                  * 16'($signed(weights[8*k +: 8]));
      end
    end
  end

  always_comb begin
    v2_d   = v1_q;
    fd2_d  = fd1_q;
    col2_d = col1_q;
    row2_d = row1_q;
    for (int r = 0; r < WIN_H; r++) begin
      rsum_d[r] = '0;
      for (int c = 0; c < WIN_W; c++) begin
        rsum_d[r] = rsum_d[r] + RSW'(prod_q[r*WIN_W + c]);
      end
    end
  end

  // Output registers hold their last value between valid results.
  always_comb begin
    ov_d   = v2_q;
    fdo_d  = v2_q && fd2_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    res_d  = res_q;
    if (v2_q) begin
      ocol_d = col2_q;
      orow_d = row2_q;
      res_d  = '0;
      for (int r = 0; r < WIN_H; r++) begin
        res_d = res_d + RES_W'(rsum_q[r]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      v0_q   <= 1'b0;
      fd0_q  <= 1'b0;
      col0_q <= '0;
      row0_q <= '0;
      v1_q   <= 1'b0;
      fd1_q  <= 1'b0;
      col1_q <= '0;
      row1_q <= '0;
      for (int k = 0; k < N; k++) prod_q[k] <= '0;
      v2_q   <= 1'b0;
      fd2_q  <= 1'b0;
      col2_q <= '0;
      row2_q <= '0;
      for (int r = 0; r < WIN_H; r++) rsum_q[r] <= '0;
      ov_q   <= 1'b0;
      fdo_q  <= 1'b0;
      ocol_q <= '0;
      orow_q <= '0;
      res_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      v0_q   <= v0_d;
      fd0_q  <= fd0_d;
      col0_q <= col0_d;
      row0_q <= row0_d;
      v1_q   <= v1_d;
      fd1_q  <= fd1_d;
      col1_q <= col1_d;
      row1_q <= row1_d;
      for (int k = 0; k < N; k++) prod_q[k] <= prod_d[k];
      v2_q   <= v2_d;
      fd2_q  <= fd2_d;
      col2_q <= col2_d;
      row2_q <= row2_d;
      for (int r = 0; r < WIN_H; r++) rsum_q[r] <= rsum_d[r];
      ov_q   <= ov_d;
      fdo_q  <= fdo_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      res_q  <= res_d;
    end
  end

  assign result     = res_q;
  assign out_valid  = ov_q;
  assign out_col    = ocol_q;
  assign out_row    = orow_q;
  assign frame_done = fdo_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac on a 5x5 image with a 3x3 window;
// the bench plays the upstream shift register and predicts each result.
module tb_conv_window_mac;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               pixel_valid = 1'b0;
  logic [71:0]        window_in = '0;
  logic [71:0]        weights = '0;
  logic signed [19:0] result;
  logic               out_valid;
  logic [2:0]         out_col;
  logic [2:0]         out_row;
  logic               frame_done;

  conv_window_mac #(
    .WIN_W(3), .WIN_H(3), .IMG_W(5), .IMG_H(5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pixel_valid(pixel_valid),
    .window_in  (window_in),
    .weights    (weights),
    .result     (result),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int res;
    int col;
    int row;
    bit fd;
    int t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   tc = 0;
  int   tr = 0;
  int   img [5][5];
  int   wt [9];
  bit   use_const = 1'b0;
  int   cexp = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int pix(int c, int r, int k);
    int x = c - 2 + k % 3;
    int y = r - 2 + k / 3;
    if (x < 0 || y < 0) return 0;
    return img[y][x];
  endfunction

  function automatic int dot(int c, int r);
    int s = 0;
    for (int k = 0; k < 9; k++) s += pix(c, r, k) * wt[k];
    return s;
  endfunction

  task automatic set_weights();
    for (int k = 0; k < 9; k++) weights[8*k +: 8] = 8'(wt[k]);
  endtask

  task automatic px(input bit pv);
    exp_t e;
    pixel_valid = pv;
    if (pv && tc >= 2 && tr >= 2) begin
      e.res = use_const ? cexp : dot(tc, tr);
      e.col = tc;
      e.row = tr;
      e.fd  = (tc == 4 && tr == 4);
      e.t   = cyc;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (pv) begin
      for (int k = 0; k < 9; k++) window_in[8*k +: 8] = 8'(pix(tc, tr, k));
      if (tc == 4) begin
        tc = 0;
        tr = (tr == 4) ? 0 : tr + 1;
      end else begin
        tc = tc + 1;
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if (out_valid !== 1'b0 || result !== '0 || out_col !== '0 ||
        out_row !== '0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got ov=%b res=%0d col=%0d row=%0d fd=%b, need all 0",
               nm, out_valid, result, out_col, out_row, frame_done);
    end
  endtask

  task automatic chk_end(input string nm, input int want);
    for (int i = 0; i < 6; i++) px(1'b0);
    n_cmp++;
    if (n_out != want || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d outputs, %0d left pending, need %0d and 0",
               nm, n_out, sb.size(), want);
    end
    n_out = 0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (frame_done && !out_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL fd_alone: got frame_done=1 with out_valid=0, need 0");
    end
    if (out_valid) begin
      n_out++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected: got out (%0d,%0d) res=%0d, need no output",
                 out_col, out_row, result);
      end else begin
        e = sb.pop_front();
        if (int'(result) != e.res || int'(out_col) != e.col ||
            int'(out_row) != e.row || frame_done != e.fd ||
            cyc != e.t + 4) begin
          n_err++;
          $display("FAIL out: got res=%0d (%0d,%0d) fd=%b cyc=%0d, need res=%0d (%0d,%0d) fd=%b cyc=%0d",
                   result, out_col, out_row, frame_done, cyc,
                   e.res, e.col, e.row, e.fd, e.t + 4);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset_init");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // all ones: nine results of 9, frame_done on (4,4)
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) img[y][x] = 1;
    for (int k = 0; k < 9; k++) wt[k] = 1;
    set_weights();
    use_const = 1'b1;
    cexp = 9;
    for (int i = 0; i < 25; i++) px(1'b1);
    chk_end("ones_count", 9);

    // extreme negative pixels and weights
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) img[y][x] = -128;
    for (int k = 0; k < 9; k++) wt[k] = -128;
    set_weights();
    cexp = 147456;
    for (int i = 0; i < 25; i++) px(1'b1);
    chk_end("neg_neg_count", 9);

    for (int k = 0; k < 9; k++) wt[k] = 127;
    set_weights();
    cexp = -146304;
    for (int i = 0; i < 25; i++) px(1'b1);
    chk_end("neg_pos_count", 9);

    // ramp with only element 0 weighted
    use_const = 1'b0;
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) img[y][x] = y*5 + x;
    for (int k = 0; k < 9; k++) wt[k] = (k == 0) ? 1 : 0;
    set_weights();
    for (int i = 0; i < 25; i++) px(1'b1);
    chk_end("ramp_count", 9);

    // two frames with random gaps, mixed-sign weights
    for (int k = 0; k < 9; k++) wt[k] = k - 4;
    set_weights();
    for (int i = 0; i < 50; i++) begin
      while ($urandom_range(0, 2) == 0) px(1'b0);
      px(1'b1);
    end
    chk_end("gaps_count", 18);

    // reset two cycles after pixel (3,3)
    for (int i = 0; i < 19; i++) px(1'b1);
    px(1'b1);
    reset = 1'b1;
    pixel_valid = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    tc = 0;
    tr = 0;
    pixel_valid = 1'b0;
    chk_zero("reset_mid_a");
    @(posedge clock);
    #1;
    chk_zero("reset_mid_b");
    reset = 1'b0;
    for (int i = 0; i < 25; i++) px(1'b1);
    chk_end("after_reset_count", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
